aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words (4/6/8 for AES-128/192/256).
REQ-002 SHALL have parameter NR, default 10, meaning round count (10/12/14, paired with NK 4/6/8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, meaning a request to expand the key currently on the key port.
REQ-006 SHALL have port key, input, NK*32, meaning the cipher key, MSB-first ([0:NK*32-1]), word 0 = bits [0:31].
REQ-007 SHALL have port busy, output, 1, meaning expansion is in progress.
REQ-008 SHALL have port key_valid, output, 1, meaning all 4*NR+4 schedule words are stored and valid.
REQ-009 SHALL have port rk_idx, input, 4, meaning the round-key select (0..NR).
REQ-010 SHALL have port rk, output, 128, meaning round key rk_idx = words 4*rk_idx..4*rk_idx+3, MSB-first, combinational read.
REQ-011 SHALL have port zeroize, input, 1, meaning a clear of key storage, present only under AES_KEYEXP_ZEROIZE_EN.

Function
REQ-012 SHALL implement the FSM states IDLE, EXPAND and READY.
REQ-013 SHALL, in IDLE or READY, accept start=1 at edge T: load words 0..NK-1 from key, clear key_valid, set busy, init rcon=8'h01, set word counter i=NK, and go to EXPAND.
REQ-014 SHALL, in EXPAND, write one word per cycle: w[i] = w[i-NK] ^ g(w[i-1]).
REQ-015 SHALL compute g as follows: SubWord(RotWord(x))^{rcon,24'h0} if i%NK==0; SubWord(x) if NK>6 and i%NK==4; otherwise x.
REQ-016 SHALL advance rcon by xtime (shift left, ^8'h1b on carry) after each i%NK==0 word; no rcon lookup table.
REQ-017 SHALL track i%NK with a separate modulo counter; no divider.
REQ-018 SHALL write the last word w[4*NR+3] at edge T+4*NR+4-NK (40 cycles for AES-128, 46 for AES-192, 52 for AES-256).
REQ-019 SHALL, at that same edge, go to READY, deassert busy and assert key_valid.
REQ-020 SHALL ignore start while busy=1; the expansion in flight is not disturbed.
REQ-021 SHALL sample key only at the accept edge; key changes afterwards have no effect.
REQ-022 SHALL drive rk from stored words regardless of key_valid, so partial contents are visible during EXPAND.
REQ-023 SHALL drive rk to 128'h0 when rk_idx>NR.
REQ-024 SHALL hold key_valid and the stored schedule in READY until the next accepted start, reset or zeroize.

Reset
REQ-025 SHALL, on rst=1 asynchronously: state=IDLE, busy=0, key_valid=0, all stored words=0, rcon=8'h01, counters=0.
REQ-026 SHALL abort an expansion in progress on reset mid-EXPAND; no partial key_valid.
REQ-027 SHALL not accept start on the first edge after rst deasserts unless start=1 at that edge.

Configuration
REQ-028 SHALL, with AES_KEYEXP_ZEROIZE_EN defined, make zeroize=1 at an edge clear all words, busy and key_valid and go to IDLE, with priority over a simultaneous start.
REQ-029 SHALL, without AES_KEYEXP_ZEROIZE_EN, omit the zeroize port; storage is cleared only by rst.

Structure
REQ-030 SHALL take from shared package aes_pkg: NB=4, typedef word_t (32-bit), typedef block_t (128-bit), and the xtime function.
REQ-031 SHALL put the byte S-box in sub-module aes_sbox (combinational, 8-bit in/out), instantiated four times for SubWord.
REQ-032 SHALL store words in a (4*NR+4) x 32 register array; no RAM macro.

Verification
REQ-033 SHALL check: NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> key_valid after 40 cycles; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL check: NK=6, NR=12, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_valid after 46 cycles; rk_idx=12 last word = 01002202.
REQ-035 SHALL check: NK=8, NR=14, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_valid after 52 cycles; rk_idx=14 last word = 706c631e.
REQ-036 SHALL check: start pulsed again at cycle 20 of an AES-128 expansion -> ignored, key_valid still rises at cycle 40, rk_idx=10 unchanged from the REQ-033 value.
REQ-037 SHALL check: rst asserted mid-EXPAND with no clock edge -> busy=0, key_valid=0, rk=0 immediately; a fresh start reproduces the REQ-033 results.
REQ-038 SHALL check (with AES_KEYEXP_ZEROIZE_EN): zeroize and start together in READY -> IDLE, rk_idx=0 reads 0, key_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions.
//   NB      - columns in the AES state, in 32-bit words
//   word_t  - one 32-bit key-schedule word
//   block_t - one 128-bit block or round key
//   kexp_state_e - control states of the key expander
//   xtime() - multiply a byte by x in GF(2^8); used to step the round constant
package aes_pkg;

  localparam int NB = 4;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } kexp_state_e;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, one byte.
//   in_i  [7:0] - input byte
//   out_o [7:0] - substituted byte
// The table is a 2048-bit constant; entry 0 sits in the most significant byte.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n lives at bit offset (255-n)*8, and 255-n is simply ~n.
  always_comb begin
    out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES key schedule, one word per clock.
// Parameters: NK key words (4/6/8), NR rounds (10/12/14).
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - expand the key on 'key' (ignored while busy)
//   key       - cipher key, word 0 in the most significant 32 bits
//   busy      - expansion in progress
//   key_valid - full schedule stored
//   rk_idx    - round-key select 0..NR
//   rk        - round key rk_idx (combinational read, 0 when rk_idx>NR)
//   zeroize   - clear storage, present only when AES_KEYEXP_ZEROIZE_EN is defined
// Optional feature macro: AES_KEYEXP_ZEROIZE_EN.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  output logic             busy,
  output logic             key_valid,
  input  logic [3:0]       rk_idx,
  output logic [127:0]     rk
`ifdef AES_KEYEXP_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  localparam int NW = NB * NR + NB;

  kexp_state_e state_q, state_d;
  word_t       w_q [NW];
  logic [7:0]  rcon_q, rcon_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  mod_q, mod_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        load_s, wr_s, clr_s, zero_s;
  word_t       prev_s, back_s, sb_in_s, sb_out_s, g_s, new_w_s;
  logic [5:0]  base_s;
  block_t      rk_s;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign zero_s = zeroize;
`else
  assign zero_s = 1'b0;
`endif

  // SubWord: four parallel byte substitutions.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sb_in_s[8*b +: 8]),
      .out_o (sb_out_s[8*b +: 8])
    );
  end

  // New schedule word w[i] = w[i-NK] ^ g(w[i-1]); only meaningful in EXPAND.
  always_comb begin
    prev_s  = w_q[i_q - 6'd1];
    back_s  = w_q[i_q - 6'(NK)];
    sb_in_s = (mod_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
    if (mod_q == 3'd0) begin
      g_s = sb_out_s ^ {rcon_q, 24'h000000};
    end else if ((NK > 6) && (mod_q == 3'd4)) begin
      g_s = sb_out_s;
    end else begin
      g_s = prev_s;
    end
    new_w_s = back_s ^ g_s;
  end

  // Control: next state, counters, round constant and storage strobes.
  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    i_d     = i_q;
    mod_d   = mod_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    load_s  = 1'b0;
    wr_s    = 1'b0;
    clr_s   = 1'b0;
    if (zero_s) begin
      // Zeroize outranks a simultaneous start.
      clr_s   = 1'b1;
      state_d = IDLE;
      rcon_d  = 8'h01;
      i_d     = 6'd0;
      mod_d   = 3'd0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (start) begin
            load_s  = 1'b1;
            state_d = EXPAND;
            rcon_d  = 8'h01;
            i_d     = 6'(NK);
            mod_d   = 3'd0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        EXPAND: begin
          wr_s  = 1'b1;
          i_d   = i_q + 6'd1;
          mod_d = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) begin
            rcon_d = xtime(rcon_q);
          end else begin
            rcon_d = rcon_q;
          end
          if (i_q == 6'(NW - 1)) begin
            state_d = READY;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            state_d = EXPAND;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcon_q  <= 8'h01;
      i_q     <= 6'd0;
      mod_q   <= 3'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      i_q     <= i_d;
      mod_q   <= mod_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Schedule word storage: key load, one-word writes, and clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (clr_s) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (load_s) begin
      for (int k = 0; k < NK; k++) w_q[k] <= key[(NK-1-k)*32 +: 32];
    end else if (wr_s) begin
      w_q[i_q] <= new_w_s;
    end
  end

  // Round-key read; stored words are shown even while expansion is running.
  always_comb begin
    base_s = {rk_idx, 2'b00};
    if (rk_idx <= 4'(NR)) begin
      rk_s = {w_q[base_s], w_q[base_s + 6'd1], w_q[base_s + 6'd2], w_q[base_s + 6'd3]};
    end else begin
      rk_s = '0;
    end
  end

  assign rk        = rk_s;
  assign busy      = busy_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand: AES-128/192/256 instances driven from one clock,
// expected round keys queued at stimulus time and compared once key_valid rises.
module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start128, start192, start256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [3:0]   rkidx128, rkidx192, rkidx256;
  logic [127:0] rk128, rk192, rk256;
  logic         busy128, busy192, busy256;
  logic         valid128, valid192, valid256;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize_s;
`endif

  aes_key_expand #(.NK(4), .NR(10)) u_dut128 (
    .clk(clk), .rst(rst), .start(start128), .key(key128), .busy(busy128),
    .key_valid(valid128), .rk_idx(rkidx128), .rk(rk128)
`ifdef AES_KEYEXP_ZEROIZE_EN
    , .zeroize(zeroize_s)
`endif
  );

  aes_key_expand #(.NK(6), .NR(12)) u_dut192 (
    .clk(clk), .rst(rst), .start(start192), .key(key192), .busy(busy192),
    .key_valid(valid192), .rk_idx(rkidx192), .rk(rk192)
`ifdef AES_KEYEXP_ZEROIZE_EN
    , .zeroize(1'b0)
`endif
  );

  aes_key_expand #(.NK(8), .NR(14)) u_dut256 (
    .clk(clk), .rst(rst), .start(start256), .key(key256), .busy(busy256),
    .key_valid(valid256), .rk_idx(rkidx256), .rk(rk256)
`ifdef AES_KEYEXP_ZEROIZE_EN
    , .zeroize(1'b0)
`endif
  );

  typedef struct {
    int           sel;
    string        tag;
    logic [3:0]   idx;
    logic [127:0] exp;
    logic [127:0] mask;
  } sb_item_t;

  sb_item_t sb[$];
  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] ALL = {128{1'b1}};
  localparam logic [127:0] LO32 = 128'h0000000000000000000000000ffffffff;
  localparam logic [127:0] HI64 = 128'hffffffffffffffff0000000000000000;
  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [3:0] idx,
                      input logic [127:0] exp, input logic [127:0] mask);
    sb_item_t it;
    it.sel = sel; it.tag = tag; it.idx = idx; it.exp = exp; it.mask = mask;
    sb.push_back(it);
  endtask

  function automatic logic get_valid(input int sel);
    case (sel)
      0:       return valid128;
      1:       return valid192;
      default: return valid256;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy128;
      1:       return busy192;
      default: return busy256;
    endcase
  endfunction

  function automatic logic [127:0] get_rk(input int sel);
    case (sel)
      0:       return rk128;
      1:       return rk192;
      default: return rk256;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start128 = v;
      1:       start192 = v;
      default: start256 = v;
    endcase
  endtask

  task automatic set_idx(input int sel, input logic [3:0] v);
    case (sel)
      0:       rkidx128 = v;
      1:       rkidx192 = v;
      default: rkidx256 = v;
    endcase
  endtask

  // Start an expansion, count edges to key_valid, then drain the scoreboard.
  task automatic expand_and_check(input int sel, input int exp_lat, input int restart_at);
    int       cycles;
    logic     busy_ok;
    sb_item_t it;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    chk("busy_after_accept", 128'(get_busy(sel)), 128'd1);
    chk("valid_cleared", 128'(get_valid(sel)), 128'd0);
    cycles  = 0;
    busy_ok = 1'b1;
    while (cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (get_valid(sel)) break;
      if (!get_busy(sel)) busy_ok = 1'b0;
      if (restart_at != 0 && cycles == restart_at) begin
        set_start(sel, 1'b1);
        key128 = ~key128;
      end else begin
        set_start(sel, 1'b0);
      end
    end
    set_start(sel, 1'b0);
    chk("latency", 128'(cycles), 128'(exp_lat));
    chk("busy_dropped", 128'(get_busy(sel)), 128'd0);
    chk("busy_held", 128'(busy_ok), 128'd1);
    while (sb.size() != 0 && sb[0].sel == sel) begin
      it = sb.pop_front();
      set_idx(sel, it.idx);
      #1;
      chk(it.tag, get_rk(sel) & it.mask, it.exp & it.mask);
    end
  endtask

  initial begin
    rst = 1'b1;
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
    rkidx128 = 4'd0; rkidx192 = 4'd0; rkidx256 = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize_s = 1'b0;
`endif
    #12;
    chk("rst_busy", {125'd0, busy128, busy192, busy256}, 128'd0);
    chk("rst_valid", {125'd0, valid128, valid192, valid256}, 128'd0);
    chk("rst_rk128", rk128, 128'd0);
    chk("rst_rk192", rk192, 128'd0);
    chk("rst_rk256", rk256, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("no_start_after_rst", 128'(busy128), 128'd0);

    // AES-128 reference schedule, including out-of-range selects.
    key128 = KEY128;
    push(0, "a128_rk0", 4'd0, KEY128, ALL);
    push(0, "a128_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, ALL);
    push(0, "a128_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL);
    push(0, "a128_rk11_zero", 4'd11, 128'd0, ALL);
    push(0, "a128_rk15_zero", 4'd15, 128'd0, ALL);
    expand_and_check(0, 40, 0);

    // Second start and key change mid-expansion must have no effect.
    key128 = KEY128;
    push(0, "restart_rk0", 4'd0, KEY128, ALL);
    push(0, "restart_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL);
    expand_and_check(0, 40, 20);
    key128 = KEY128;

    // Reset mid-expansion clears everything without a clock edge.
    @(negedge clk);
    start128 = 1'b1;
    @(posedge clk);
    #1;
    start128 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rkidx128 = 4'd1;
    #1;
    chk("partial_rk1", rk128 & HI64, 128'ha0fafe1788542cb10000000000000000);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy128), 128'd0);
    chk("midrst_valid", 128'(valid128), 128'd0);
    rkidx128 = 4'd0;
    #1;
    chk("midrst_rk0", rk128, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stays_idle", 128'(busy128), 128'd0);
    push(0, "fresh_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, ALL);
    push(0, "fresh_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ALL);
    expand_and_check(0, 40, 0);

    // AES-192.
    key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    push(1, "a192_rk0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5, ALL);
    push(1, "a192_rk12_w3", 4'd12, 128'h01002202, LO32);
    push(1, "a192_rk13_zero", 4'd13, 128'd0, ALL);
    expand_and_check(1, 46, 0);

    // AES-256.
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    push(2, "a256_rk0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781, ALL);
    push(2, "a256_rk14_w3", 4'd14, 128'h706c631e, LO32);
    push(2, "a256_rk15_zero", 4'd15, 128'd0, ALL);
    expand_and_check(2, 52, 0);

`ifdef AES_KEYEXP_ZEROIZE_EN
    // Zeroize together with start in READY wins.
    @(negedge clk);
    zeroize_s = 1'b1;
    start128  = 1'b1;
    @(posedge clk);
    #1;
    zeroize_s = 1'b0;
    start128  = 1'b0;
    rkidx128  = 4'd0;
    #1;
    chk("zero_busy", 128'(busy128), 128'd0);
    chk("zero_valid", 128'(valid128), 128'd0);
    chk("zero_rk0", rk128, 128'd0);
`endif

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
